rob_dur_sched: RTL and testbench

ROB_DUR_SCHED -- requirements
Module: rob_dur_sched

---
 rtl/rob_dur_pkg.sv | 29 ++
 rtl/rob_dur_acc.sv | 72 +++++++
 rtl/rob_dur_sched.sv | 190 +++++++++++++++++++
 tb/tb_rob_dur_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_dur_pkg.sv
// Shared definitions for the ROB duration scheduler.
// Holds the datapath widths, the scheduler FSM state enum and the per-class
// report payload. The payload carries a per-window maximum only when
// ROB_DUR_SCHED_MAX_EN is defined.
package rob_dur_pkg;

    localparam int unsigned DURATION_WIDTH = 10;
    localparam int unsigned SUM_WIDTH      = 18;
    localparam int unsigned CNT_WIDTH      = 9;
    localparam int unsigned CTR_WIDTH      = 8;
    localparam int unsigned PRESC_WIDTH    = 14;
    localparam int unsigned TS_WIDTH       = 10;
    localparam int unsigned DROP_WIDTH     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } rob_state_e;

    typedef struct packed {
        logic [SUM_WIDTH-1:0]      sum;
        logic [CNT_WIDTH-1:0]      cnt;
`ifdef ROB_DUR_SCHED_MAX_EN
        logic [DURATION_WIDTH-1:0] max_dur;
`endif
    } rob_rpt_t;

endpackage

// File: rtl/rob_dur_acc.sv
// One duration class: accumulates durations and counts samples for a window,
// with an optional running maximum (ROB_DUR_SCHED_MAX_EN).
// Ports:
//   clk, reset   - clock, async active-low reset
//   clr_i        - clear sum/count(/max); wins over add_i
//   add_i        - accept dur_i into the window
//   dur_i        - duration sample
//   rpt_o        - registered sum/count(/max) payload
module rob_dur_acc
    import rob_dur_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr_i,
    input  logic                      add_i,
    input  logic [DURATION_WIDTH-1:0] dur_i,
    output rob_rpt_t                  rpt_o
);

    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Sum cannot overflow: 1023 * 256 fits in 18 bits.
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + SUM_WIDTH'(dur_i);
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign rpt_o.sum = sum_q;
    assign rpt_o.cnt = cnt_q;

`ifdef ROB_DUR_SCHED_MAX_EN
    logic [DURATION_WIDTH-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (clr_i) begin
            max_d = '0;
        end else if (add_i && (dur_i > max_q)) begin
            max_d = dur_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign rpt_o.max_dur = max_q;
`endif

endmodule

// File: rtl/rob_dur_sched.sv
// ROB duration scheduler: arms dispatch/writeback duration monitors through
// two phase counters, accumulates their results over a window of
// 2^WIN_LOG2 dispatch samples and hands the window out as a valid/ready report.
// Ports:
//   clk, reset                  - clock, async active-low reset
//   enable                      - run sampling
//   counter_in / counter_wb     - dispatch / writeback arm phase (0 arms)
//   timestamp                   - prescaled duration timebase
//   dur_* / upd_*               - monitor results and their write pulses
//   rpt_valid / rpt_ready       - report handshake
//   rpt_sum_* / rpt_cnt_*       - window sums and sample counts
//   rpt_drop                    - results dropped since previous report
//   rpt_max_*                   - per-window maxima (only with ROB_DUR_SCHED_MAX_EN)
module rob_dur_sched
    import rob_dur_pkg::*;
#(
    parameter int unsigned WIN_LOG2  = 4,
    parameter logic [7:0]  WB_OFFSET = 8'd128
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    output logic [CTR_WIDTH-1:0]      counter_in,
    output logic [CTR_WIDTH-1:0]      counter_wb,
    output logic [TS_WIDTH-1:0]       timestamp,
    input  logic [DURATION_WIDTH-1:0] dur_dp,
    input  logic [DURATION_WIDTH-1:0] dur_fast,
    input  logic [DURATION_WIDTH-1:0] dur_slow,
    input  logic                      upd_dp,
    input  logic                      upd_fast,
    input  logic                      upd_slow,
    output logic                      rpt_valid,
    input  logic                      rpt_ready,
    output logic [SUM_WIDTH-1:0]      rpt_sum_dp,
    output logic [SUM_WIDTH-1:0]      rpt_sum_fast,
    output logic [SUM_WIDTH-1:0]      rpt_sum_slow,
    output logic [CNT_WIDTH-1:0]      rpt_cnt_dp,
    output logic [CNT_WIDTH-1:0]      rpt_cnt_fast,
    output logic [CNT_WIDTH-1:0]      rpt_cnt_slow,
`ifdef ROB_DUR_SCHED_MAX_EN
    output logic [DURATION_WIDTH-1:0] rpt_max_dp,
    output logic [DURATION_WIDTH-1:0] rpt_max_fast,
    output logic [DURATION_WIDTH-1:0] rpt_max_slow,
`endif
    output logic [DROP_WIDTH-1:0]     rpt_drop
);

    localparam int unsigned          WIN_SAMPLES = 1 << WIN_LOG2;
    localparam logic [CNT_WIDTH-1:0] WIN_LAST    = CNT_WIDTH'(WIN_SAMPLES - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_PARK    = CTR_WIDTH'(1);
    localparam logic [CTR_WIDTH-1:0] CTR_START   = CTR_WIDTH'(255);
    localparam int unsigned          DROP_SUM_W  = DROP_WIDTH + 1;

    rob_state_e             state_q, state_d;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic [CTR_WIDTH-1:0]   ctr_in_q, ctr_in_d;
    logic [CTR_WIDTH-1:0]   ctr_wb_q, ctr_wb_d;
    logic [DROP_WIDTH-1:0]  drop_q, drop_d;
    logic [DROP_WIDTH-1:0]  rpt_drop_q, rpt_drop_d;
    logic                   rpt_valid_q, rpt_valid_d;
    logic                   handshake_c, win_done_c;
    logic                   acc_add_c, acc_clr_c;
    logic [DROP_SUM_W-1:0]  drop_sum_c;
    logic [DROP_WIDTH-1:0]  drop_sat_c;
    rob_rpt_t               acc_dp, acc_fast, acc_slow;

    assign handshake_c = (state_q == ST_REPORT) && rpt_ready;
    assign win_done_c  = upd_dp && (acc_dp.cnt == WIN_LAST);

    // Every pulse seen outside RUN is a drop; at most three per cycle.
    assign drop_sum_c = {1'b0, drop_q} + DROP_SUM_W'(upd_dp)
                      + DROP_SUM_W'(upd_fast) + DROP_SUM_W'(upd_slow);
    assign drop_sat_c = drop_sum_c[DROP_WIDTH] ? '1 : drop_sum_c[DROP_WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable loss in RUN wins over window completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (win_done_c) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: if (rpt_ready) state_d = enable ? ST_RUN : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output/next-value logic. The live drop counter restarts when a report is
    // captured, so drops arriving while a report waits land in the next one.
    always_comb begin
        ctr_in_d    = CTR_PARK;
        ctr_wb_d    = CTR_PARK;
        drop_d      = drop_q;
        rpt_drop_d  = rpt_drop_q;
        rpt_valid_d = (state_d == ST_REPORT);
        acc_add_c   = (state_q == ST_RUN) && enable;
        acc_clr_c   = ((state_q == ST_RUN) && !enable) || handshake_c;
        if (state_d == ST_RUN) begin
            ctr_in_d = (state_q == ST_RUN) ? ctr_in_q - CTR_WIDTH'(1) : CTR_START;
            ctr_wb_d = ctr_in_d + WB_OFFSET;
        end
        if (state_q != ST_RUN) begin
            drop_d = drop_sat_c;
        end
        if ((state_q == ST_RUN) && (state_d == ST_REPORT)) begin
            rpt_drop_d = drop_q;
            drop_d     = '0;
        end
        if (handshake_c) begin
            rpt_drop_d = '0;
        end
    end

    // Datapath registers; the prescaler runs in every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q     <= '0;
            ctr_in_q    <= CTR_PARK;
            ctr_wb_q    <= CTR_PARK;
            drop_q      <= '0;
            rpt_drop_q  <= '0;
            rpt_valid_q <= 1'b0;
        end else begin
            presc_q     <= presc_q + PRESC_WIDTH'(1);
            ctr_in_q    <= ctr_in_d;
            ctr_wb_q    <= ctr_wb_d;
            drop_q      <= drop_d;
            rpt_drop_q  <= rpt_drop_d;
            rpt_valid_q <= rpt_valid_d;
        end
    end

    rob_dur_acc u_acc_dp (
        .clk   (clk),
        .reset (reset),
        .clr_i (acc_clr_c),
        .add_i (acc_add_c && upd_dp),
        .dur_i (dur_dp),
        .rpt_o (acc_dp)
    );

    rob_dur_acc u_acc_fast (
        .clk   (clk),
        .reset (reset),
        .clr_i (acc_clr_c),
        .add_i (acc_add_c && upd_fast),
        .dur_i (dur_fast),
        .rpt_o (acc_fast)
    );

    rob_dur_acc u_acc_slow (
        .clk   (clk),
        .reset (reset),
        .clr_i (acc_clr_c),
        .add_i (acc_add_c && upd_slow),
        .dur_i (dur_slow),
        .rpt_o (acc_slow)
    );

    assign counter_in   = ctr_in_q;
    assign counter_wb   = ctr_wb_q;
    assign timestamp    = presc_q[PRESC_WIDTH-1:PRESC_WIDTH-TS_WIDTH];
    assign rpt_valid    = rpt_valid_q;
    assign rpt_drop     = rpt_drop_q;
    assign rpt_sum_dp   = acc_dp.sum;
    assign rpt_sum_fast = acc_fast.sum;
    assign rpt_sum_slow = acc_slow.sum;
    assign rpt_cnt_dp   = acc_dp.cnt;
    assign rpt_cnt_fast = acc_fast.cnt;
    assign rpt_cnt_slow = acc_slow.cnt;
`ifdef ROB_DUR_SCHED_MAX_EN
    assign rpt_max_dp   = acc_dp.max_dur;
    assign rpt_max_fast = acc_fast.max_dur;
    assign rpt_max_slow = acc_slow.max_dur;
`endif

endmodule

// File: tb/tb_rob_dur_sched.sv
// Testbench for rob_dur_sched (WIN_LOG2 = 2). Directed table, hand-written
// corner sequences and random traffic, all compared against a window-queue
// reference model. Build with ROB_DUR_SCHED_MAX_EN to also cover maxima.
module tb_rob_dur_sched;

    localparam int unsigned WIN_LOG2 = 2;
    localparam int          WIN      = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable = 1'b0;
    logic [7:0] counter_in, counter_wb;
    logic [9:0] timestamp;
    logic [9:0] dur_dp = '0, dur_fast = '0, dur_slow = '0;
    logic       upd_dp = 1'b0, upd_fast = 1'b0, upd_slow = 1'b0;
    logic       rpt_valid;
    logic       rpt_ready = 1'b0;
    logic [17:0] rpt_sum_dp, rpt_sum_fast, rpt_sum_slow;
    logic [8:0]  rpt_cnt_dp, rpt_cnt_fast, rpt_cnt_slow;
    logic [3:0]  rpt_drop;
`ifdef ROB_DUR_SCHED_MAX_EN
    logic [9:0]  rpt_max_dp, rpt_max_fast, rpt_max_slow;
`endif

    always #5 clk = ~clk;

    rob_dur_sched #(.WIN_LOG2(WIN_LOG2), .WB_OFFSET(8'd128)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .counter_in   (counter_in),
        .counter_wb   (counter_wb),
        .timestamp    (timestamp),
        .dur_dp       (dur_dp),
        .dur_fast     (dur_fast),
        .dur_slow     (dur_slow),
        .upd_dp       (upd_dp),
        .upd_fast     (upd_fast),
        .upd_slow     (upd_slow),
        .rpt_valid    (rpt_valid),
        .rpt_ready    (rpt_ready),
        .rpt_sum_dp   (rpt_sum_dp),
        .rpt_sum_fast (rpt_sum_fast),
        .rpt_sum_slow (rpt_sum_slow),
        .rpt_cnt_dp   (rpt_cnt_dp),
        .rpt_cnt_fast (rpt_cnt_fast),
        .rpt_cnt_slow (rpt_cnt_slow),
`ifdef ROB_DUR_SCHED_MAX_EN
        .rpt_max_dp   (rpt_max_dp),
        .rpt_max_fast (rpt_max_fast),
        .rpt_max_slow (rpt_max_slow),
`endif
        .rpt_drop     (rpt_drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the open window is kept as one queue of samples per class.
    int m_mode;        // 0 idle, 1 run, 2 report
    int m_cin;
    int m_t;
    int m_drop_live;
    int m_drop_rpt;
    int wq[3][$];

    function automatic int qsum(input int c);
        int s = 0;
        for (int i = 0; i < wq[c].size(); i++) s += wq[c][i];
        return s;
    endfunction

    function automatic int qmax(input int c);
        int m = 0;
        for (int i = 0; i < wq[c].size(); i++) if (wq[c][i] > m) m = wq[c][i];
        return m;
    endfunction

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cin = 1; m_t = 0; m_drop_live = 0; m_drop_rpt = 0;
        for (int c = 0; c < 3; c++) wq[c].delete();
    endtask

    task automatic model_step(input logic en, input logic [2:0] upd, input int d0,
                              input int d1, input int d2, input logic rdy);
        int n;
        int d[3];
        n = int'(upd[0]) + int'(upd[1]) + int'(upd[2]);
        d[0] = d0; d[1] = d1; d[2] = d2;
        m_t = (m_t + 1) % 16384;
        case (m_mode)
            0: begin
                m_drop_live = sat15(m_drop_live + n);
                if (en) begin m_mode = 1; m_cin = 255; end
            end
            1: begin
                if (!en) begin
                    for (int c = 0; c < 3; c++) wq[c].delete();
                    m_mode = 0; m_cin = 1;
                end else begin
                    for (int c = 0; c < 3; c++) if (upd[c]) wq[c].push_back(d[c]);
                    if (upd[0] && wq[0].size() == WIN) begin
                        m_mode = 2; m_cin = 1;
                        m_drop_rpt = m_drop_live; m_drop_live = 0;
                    end else begin
                        m_cin = (m_cin + 255) % 256;
                    end
                end
            end
            default: begin
                m_drop_live = sat15(m_drop_live + n);
                if (rdy) begin
                    for (int c = 0; c < 3; c++) wq[c].delete();
                    m_drop_rpt = 0;
                    if (en) begin m_mode = 1; m_cin = 255; end
                    else begin m_mode = 0; m_cin = 1; end
                end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".counter_in"}, 32'(counter_in), m_cin);
        chk({tag, ".counter_wb"}, 32'(counter_wb), (m_mode == 1) ? (m_cin + 128) % 256 : 1);
        chk({tag, ".timestamp"}, 32'(timestamp), m_t / 16);
        chk({tag, ".rpt_valid"}, 32'(rpt_valid), (m_mode == 2) ? 1 : 0);
        chk({tag, ".rpt_drop"}, 32'(rpt_drop), m_drop_rpt);
        chk({tag, ".sum_dp"}, 32'(rpt_sum_dp), qsum(0));
        chk({tag, ".sum_fast"}, 32'(rpt_sum_fast), qsum(1));
        chk({tag, ".sum_slow"}, 32'(rpt_sum_slow), qsum(2));
        chk({tag, ".cnt_dp"}, 32'(rpt_cnt_dp), wq[0].size());
        chk({tag, ".cnt_fast"}, 32'(rpt_cnt_fast), wq[1].size());
        chk({tag, ".cnt_slow"}, 32'(rpt_cnt_slow), wq[2].size());
`ifdef ROB_DUR_SCHED_MAX_EN
        chk({tag, ".max_dp"}, 32'(rpt_max_dp), qmax(0));
        chk({tag, ".max_fast"}, 32'(rpt_max_fast), qmax(1));
        chk({tag, ".max_slow"}, 32'(rpt_max_slow), qmax(2));
`endif
    endtask

    // Apply one cycle of inputs, advance the model and compare after the edge.
    task automatic cycle(input string tag, input logic en, input logic [2:0] upd,
                         input int d0, input int d1, input int d2, input logic rdy);
        enable = en; rpt_ready = rdy;
        upd_dp = upd[0]; upd_fast = upd[1]; upd_slow = upd[2];
        dur_dp = 10'(d0); dur_fast = 10'(d1); dur_slow = 10'(d2);
        @(posedge clk);
        #1;
        model_step(en, upd, d0, d1, d2, rdy);
        check_all(tag);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".counter_in"}, 32'(counter_in), 1);
        chk({tag, ".counter_wb"}, 32'(counter_wb), 1);
        chk({tag, ".timestamp"}, 32'(timestamp), 0);
        chk({tag, ".rpt_valid"}, 32'(rpt_valid), 0);
        chk({tag, ".sum_dp"}, 32'(rpt_sum_dp), 0);
        chk({tag, ".cnt_dp"}, 32'(rpt_cnt_dp), 0);
        chk({tag, ".rpt_drop"}, 32'(rpt_drop), 0);
    endtask

    typedef struct {
        logic [2:0] upd;
        int         d0, d1, d2;
        logic       rdy;
        logic       en;
        int         e_valid, e_sum_dp, e_cnt_dp, e_sum_fast, e_sum_slow;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // upd bit 0 = dp, bit 1 = fast, bit 2 = slow
        tbl[0] = '{3'b001, 10, 0, 0, 1'b0, 1'b1, 0, 10, 1, 0, 0};
        tbl[1] = '{3'b001, 20, 0, 0, 1'b0, 1'b1, 0, 30, 2, 0, 0};
        tbl[2] = '{3'b000,  0, 0, 0, 1'b0, 1'b1, 0, 30, 2, 0, 0};
        tbl[3] = '{3'b001, 30, 0, 0, 1'b0, 1'b1, 0, 60, 3, 0, 0};
        tbl[4] = '{3'b001, 40, 0, 0, 1'b0, 1'b1, 1, 100, 4, 0, 0};
        tbl[5] = '{3'b000,  0, 0, 0, 1'b0, 1'b1, 1, 100, 4, 0, 0};
        tbl[6] = '{3'b000,  0, 0, 0, 1'b1, 1'b1, 0, 0, 0, 0, 0};
        tbl[7] = '{3'b111,  5, 6, 7, 1'b0, 1'b1, 0, 5, 1, 6, 7};
        tbl[8] = '{3'b111,  5, 6, 7, 1'b0, 1'b1, 0, 10, 2, 12, 14};
        tbl[9] = '{3'b110,  0, 100, 3, 1'b0, 1'b1, 0, 10, 2, 112, 17};

        // Reset state
        reset = 1'b1;
        #1 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_reset_values("reset");
        reset = 1'b1;
        model_reset();

        // Phase counters and timebase after reset release with enable high
        for (int i = 0; i < 300; i++) begin
            cycle("phase", 1'b1, 3'b000, 0, 0, 0, 1'b0);
            if (i == 0)   chk("phase.first", 32'(counter_in), 255);
            if (i == 255) chk("phase.zero", 32'(counter_in), 0);
            if (i == 256) chk("phase.wrap", 32'(counter_in), 255);
            if (i == 256) chk("phase.wb_wrap", 32'(counter_wb), 127);
            if (i == 14)  chk("phase.ts0", 32'(timestamp), 0);
            if (i == 15)  chk("phase.ts1", 32'(timestamp), 1);
        end

        // Directed window table
        for (int i = 0; i < 10; i++) begin
            cycle($sformatf("tbl%0d", i), tbl[i].en, tbl[i].upd, tbl[i].d0, tbl[i].d1,
                  tbl[i].d2, tbl[i].rdy);
            chk($sformatf("tbl%0d.valid", i), 32'(rpt_valid), tbl[i].e_valid);
            chk($sformatf("tbl%0d.sum_dp", i), 32'(rpt_sum_dp), tbl[i].e_sum_dp);
            chk($sformatf("tbl%0d.cnt_dp", i), 32'(rpt_cnt_dp), tbl[i].e_cnt_dp);
            chk($sformatf("tbl%0d.sum_fast", i), 32'(rpt_sum_fast), tbl[i].e_sum_fast);
            chk($sformatf("tbl%0d.sum_slow", i), 32'(rpt_sum_slow), tbl[i].e_sum_slow);
        end

        // Stalled report with drops arriving
        cycle("stall", 1'b1, 3'b001, 1, 0, 0, 1'b0);
        cycle("stall", 1'b1, 3'b001, 2, 0, 0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cycle("stall", 1'b1, (i < 40 && i % 2 == 0) ? 3'b010 : 3'b000, 0, 333, 0, 1'b0);
        end
        chk("stall.sum_dp", 32'(rpt_sum_dp), 13);
        chk("stall.sum_fast", 32'(rpt_sum_fast), 112);
        chk("stall.counter_in", 32'(counter_in), 1);
        chk("stall.counter_wb", 32'(counter_wb), 1);
        chk("stall.drop_now", 32'(rpt_drop), 0);
        cycle("stall_hs", 1'b1, 3'b000, 0, 0, 0, 1'b1);
        for (int i = 0; i < WIN; i++) cycle("drop_win", 1'b1, 3'b001, 1, 0, 0, 1'b0);
        chk("drop.valid", 32'(rpt_valid), 1);
        chk("drop.sat", 32'(rpt_drop), 15);

        // Enable falling in REPORT keeps the report
        for (int i = 0; i < 3; i++) cycle("en_rpt", 1'b0, 3'b000, 0, 0, 0, 1'b0);
        chk("en_rpt.valid", 32'(rpt_valid), 1);
        cycle("en_rpt_hs", 1'b0, 3'b000, 0, 0, 0, 1'b1);
        chk("en_rpt.idle_valid", 32'(rpt_valid), 0);
        chk("en_rpt.idle_cin", 32'(counter_in), 1);

        // Enable falling in RUN discards the window
        cycle("en_run", 1'b1, 3'b000, 0, 0, 0, 1'b0);
        cycle("en_run", 1'b1, 3'b001, 50, 0, 0, 1'b0);
        cycle("en_run", 1'b1, 3'b001, 50, 0, 0, 1'b0);
        cycle("en_run", 1'b0, 3'b000, 0, 0, 0, 1'b0);
        chk("en_run.sum_dp", 32'(rpt_sum_dp), 0);
        chk("en_run.cnt_dp", 32'(rpt_cnt_dp), 0);

        // Asynchronous reset mid-window
        cycle("mid_rst", 1'b1, 3'b000, 0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("mid_rst", 1'b1, 3'b001, 9, 0, 0, 1'b0);
        enable = 1'b0; upd_dp = 1'b0; upd_fast = 1'b0; upd_slow = 1'b0; rpt_ready = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk_reset_values("mid_rst.async");
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        cycle("post_rst", 1'b1, 3'b000, 0, 0, 0, 1'b0);
        for (int i = 0; i < WIN; i++) cycle("post_rst", 1'b1, 3'b001, 7, 0, 0, 1'b0);
        chk("post_rst.valid", 32'(rpt_valid), 1);
        chk("post_rst.sum_dp", 32'(rpt_sum_dp), 28);
        chk("post_rst.cnt_dp", 32'(rpt_cnt_dp), 4);
        cycle("post_rst_hs", 1'b1, 3'b000, 0, 0, 0, 1'b1);

`ifdef ROB_DUR_SCHED_MAX_EN
        cycle("max", 1'b1, 3'b101, 1, 0, 3, 1'b0);
        cycle("max", 1'b1, 3'b101, 1, 0, 900, 1'b0);
        cycle("max", 1'b1, 3'b101, 1, 0, 12, 1'b0);
        cycle("max", 1'b1, 3'b001, 1, 0, 0, 1'b0);
        chk("max.slow", 32'(rpt_max_slow), 900);
        cycle("max_hs", 1'b1, 3'b000, 0, 0, 0, 1'b1);
        chk("max.cleared", 32'(rpt_max_slow), 0);
`endif

        // Random traffic, long enough to wrap the prescaler
        for (int i = 0; i < 17000; i++) begin
            logic       en, rdy;
            logic [2:0] upd;
            en     = ($urandom % 32) != 0;
            rdy    = ($urandom % 4) == 0;
            upd[0] = ($urandom % 3) == 0;
            upd[1] = ($urandom % 3) == 0;
            upd[2] = ($urandom % 3) == 0;
            cycle("rand", en, upd, int'($urandom % 1024), int'($urandom % 1024),
                  int'($urandom % 1024), rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
